int_window_decoder: RTL

- Parametrised, multi-channel successor to the single-input interrupt-width decoder.
- Measures the high-pulse width of the control-strobe input INT in T1us ticks.
- Fires a stretched interrupt pulse on each channel whose programmable open window contains the measured width.
- Sits between the external controller strobe line and the local interrupt consumers. Windows, pulse lengths and enables are run-time inputs from the control register bank.

---
 rtl/int_window_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/int_window_decoder.sv
// Multi-channel interrupt-width decoder: measures the INT high width in T1us ticks
// and fires a stretched pulse on every channel whose open window contains it.
module int_window_decoder #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int LEN_W       = 17,
  parameter int SYNC_STAGES = 2,
  parameter int RETRIG      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    INT,
  input  logic                    T1us,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH*CNT_W-1:0]   win_lo,
  input  logic [N_CH*CNT_W-1:0]   win_hi,
  input  logic [N_CH*LEN_W-1:0]   out_len,
  output logic [N_CH-1:0]         int_out,
  output logic [CNT_W-1:0]        width_val,
  output logic                    width_vld,
  output logic                    width_ovf,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] WIDTH_MAX = {CNT_W{1'b1}};
  localparam bit               RETRIG_EN = (RETRIG != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_EVAL    = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  logic [SYNC_STAGES-1:0] int_sync_r, tick_sync_r;
  logic [2:0]             int_hist_r, tick_hist_r;
  logic                   rise_s, fall_s, tick_s;
  logic                   start_s, eval_s, busy_s, pend_r;
  logic [CNT_W-1:0]       width_cnt_r;
  logic                   ovf_r;
  logic [CNT_W-1:0]       width_val_r;
  logic                   width_vld_r, width_ovf_r, busy_r;
  logic [N_CH-1:0]        trig_s;

  // Synchronisers feed a 3-deep history; highs/lows under 2 clk never form 011 or 100.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_sync_r  <= {SYNC_STAGES{1'b0}};
      tick_sync_r <= {SYNC_STAGES{1'b0}};
      int_hist_r  <= 3'b000;
      tick_hist_r <= 3'b000;
    end else begin
      int_sync_r  <= SYNC_STAGES'({int_sync_r, INT});
      tick_sync_r <= SYNC_STAGES'({tick_sync_r, T1us});
      int_hist_r  <= {int_hist_r[1:0], int_sync_r[SYNC_STAGES-1]};
      tick_hist_r <= {tick_hist_r[1:0], tick_sync_r[SYNC_STAGES-1]};
    end
  end

  assign rise_s = (int_hist_r == 3'b011);
  assign fall_s = (int_hist_r == 3'b100);
  assign tick_s = (tick_hist_r == 3'b011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s || pend_r) begin
          next_state_s = ST_MEASURE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (fall_s) begin
          next_state_s = ST_EVAL;
        end else begin
          next_state_s = ST_MEASURE;
        end
      end
      ST_EVAL: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  always_comb begin
    start_s = (state_r == ST_IDLE) && (rise_s || pend_r);
    eval_s  = (state_r == ST_EVAL);
    busy_s  = (next_state_s == ST_MEASURE) || (next_state_s == ST_EVAL);
  end

  // Width measurement; a rise seen during EVAL is held in pend_r for the next IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt_r <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      pend_r      <= 1'b0;
      width_val_r <= {CNT_W{1'b0}};
      width_vld_r <= 1'b0;
      width_ovf_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      pend_r <= eval_s && rise_s;
      busy_r <= busy_s;
      if (start_s) begin
        width_cnt_r <= {CNT_W{1'b0}};
        ovf_r       <= 1'b0;
      end else if ((state_r == ST_MEASURE) && tick_s && !fall_s) begin
        if (width_cnt_r == WIDTH_MAX) begin
          ovf_r <= 1'b1;
        end else begin
          width_cnt_r <= width_cnt_r + CNT_W'(1);
        end
      end
      if (eval_s) begin
        width_val_r <= width_cnt_r;
        width_ovf_r <= ovf_r;
        width_vld_r <= 1'b1;
      end else begin
        width_vld_r <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] lo_s, hi_s;
    logic [LEN_W-1:0] len_s, len_cnt_r;
    logic             active_r;

    assign lo_s  = win_lo[k*CNT_W +: CNT_W];
    assign hi_s  = win_hi[k*CNT_W +: CNT_W];
    assign len_s = out_len[k*LEN_W +: LEN_W];
    assign trig_s[k] = eval_s && ch_en[k] && (lo_s < width_cnt_r) && (width_cnt_r < hi_s)
                       && !ovf_r && (len_s != {LEN_W{1'b0}});

    // Pulse stretcher: the count is compared live against out_len, so a shrunk length waits for wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        active_r  <= 1'b0;
        len_cnt_r <= {LEN_W{1'b0}};
      end else if (trig_s[k] && (!active_r || RETRIG_EN)) begin
        active_r  <= 1'b1;
        len_cnt_r <= {LEN_W{1'b0}};
      end else if (active_r) begin
        if (len_cnt_r == len_s) begin
          active_r  <= 1'b0;
          len_cnt_r <= {LEN_W{1'b0}};
        end else if (tick_s) begin
          len_cnt_r <= len_cnt_r + LEN_W'(1);
        end
      end
    end

    assign int_out[k] = active_r;
  end

  assign width_val = width_val_r;
  assign width_vld = width_vld_r;
  assign width_ovf = width_ovf_r;
  assign busy      = busy_r;

endmodule
